// File: rtl/mulpop_pkg.sv
// Shared types and helpers for the multiply/popcount arbiter.
// Optional build macro MULPOP_EARLY_TERM_EN is consumed by mulpop_engine.
package mulpop_pkg;

   localparam int unsigned RW  = 32;
   localparam int unsigned LW  = 6;
   localparam int unsigned IDW = 3;

   typedef enum logic [1:0] {
      StIdle,
      StMult,
      StPop,
      StResp
   } state_e;

   function automatic logic [LW-1:0] popcount(input logic [RW-1:0] v);
      logic [LW-1:0] n;
      n = '0;
      for (int i = 0; i < RW; i++) begin
         n = n + LW'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/mulpop_engine.sv
// Shift-add multiplier (one multiplier bit per cycle) with popcount/overflow of the result.
// Define MULPOP_EARLY_TERM_EN to stop once the remaining multiplier bits are all zero.
module mulpop_engine
   import mulpop_pkg::*;
#(
   parameter int unsigned AW = 24
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          start,
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] b,
   output logic          done,
   output logic [RW-1:0] w,
   output logic [LW-1:0] l,
   output logic          ovf
);

   localparam int unsigned PW = 2 * AW;
   localparam int unsigned CW = $clog2(AW);

   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] mcand_q, mcand_d;
   logic [AW-1:0] mplr_q, mplr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic          done_q, done_d;
   logic          last;

`ifdef MULPOP_EARLY_TERM_EN
   assign last = (mplr_q == '0) || (cnt_q == CW'(AW - 1));
`else
   assign last = (cnt_q == CW'(AW - 1));
`endif

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      done_d  = done_q;
      if (start) begin
         acc_d   = '0;
         mcand_d = PW'(a);
         mplr_d  = b;
         cnt_d   = '0;
         run_d   = 1'b1;
         done_d  = 1'b0;
      end else if (run_q) begin
         if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d = mcand_q << 1;
         mplr_d  = mplr_q >> 1;
         cnt_d   = cnt_q + 1'b1;
         if (last) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;
   assign w    = acc_q[RW-1:0];
   assign l    = popcount(acc_q[RW-1:0]);

   if (PW > RW) begin : g_ovf
      assign ovf = |acc_q[PW-1:RW];
   end else begin : g_no_ovf
      assign ovf = 1'b0;
   end

endmodule

// File: rtl/mulpop_arbiter.sv
// Round-robin front end sharing one mulpop_engine between NREQ requesters.
// Build macro MULPOP_EARLY_TERM_EN (engine early termination) is optional.
module mulpop_arbiter
   import mulpop_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 24
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_a,
   input  logic [NREQ*AW-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [RW-1:0]      rsp_w,
   output logic [LW-1:0]      rsp_l,
   output logic               rsp_ovf,
   output logic               busy,
   output logic [15:0]        op_count
);

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [RW-1:0]  w_q, w_d;
   logic [LW-1:0]  l_q, l_d;
   logic           ovf_q, ovf_d;
   logic [15:0]    cnt_q, cnt_d;

   logic           gnt_vld;
   logic [IDW-1:0] gnt_idx;
   logic           hi_vld, lo_vld;
   logic [IDW-1:0] hi_idx, lo_idx;
   logic [AW-1:0]  sel_a, sel_b;
   logic           start;

   logic           eng_done;
   logic [RW-1:0]  eng_w;
   logic [LW-1:0]  eng_l;
   logic           eng_ovf;

   // Lowest index above the pointer wins; otherwise wrap to the lowest index at or below it.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (IDW'(i) > ptr_q) begin
               hi_vld = 1'b1;
               hi_idx = IDW'(i);
            end else begin
               lo_vld = 1'b1;
               lo_idx = IDW'(i);
            end
         end
      end
      gnt_vld = hi_vld | lo_vld;
      gnt_idx = hi_vld ? hi_idx : lo_idx;
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a = req_a[i*AW +: AW];
            sel_b = req_b[i*AW +: AW];
         end
      end
   end

   // Gated by n_reset so every output reads 0 while reset is held.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         req_ready[i] = n_reset && (state_q == StIdle) && gnt_vld && (gnt_idx == IDW'(i));
      end
   end

   assign start = (state_q == StIdle) && gnt_vld;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      w_d     = w_q;
      l_d     = l_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_vld) begin
               ptr_d   = gnt_idx;
               id_d    = gnt_idx;
               state_d = StMult;
            end
         end
         StMult: begin
            if (eng_done) begin
               state_d = StPop;
            end
         end
         StPop: begin
            w_d     = eng_w;
            l_d     = eng_l;
            ovf_d   = eng_ovf;
            state_d = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= StIdle;
         ptr_q   <= IDW'(NREQ - 1);
         id_q    <= '0;
         w_q     <= '0;
         l_q     <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         w_q     <= w_d;
         l_q     <= l_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   mulpop_engine #(
      .AW (AW)
   ) u_engine (
      .clk     (clk),
      .n_reset (n_reset),
      .start   (start),
      .a       (sel_a),
      .b       (sel_b),
      .done    (eng_done),
      .w       (eng_w),
      .l       (eng_l),
      .ovf     (eng_ovf)
   );

   assign rsp_valid = (state_q == StResp);
   assign busy      = (state_q != StIdle);
   assign rsp_id    = id_q;
   assign rsp_w     = w_q;
   assign rsp_l     = l_q;
   assign rsp_ovf   = ovf_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_mulpop_arbiter.sv
// Directed + randomized bench for mulpop_arbiter against an arithmetic reference model.
// Latency expectations follow MULPOP_EARLY_TERM_EN when it is defined.
module tb_mulpop_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 24;

   logic               clk = 1'b0;
   logic               n_reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_a;
   logic [NREQ*AW-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [2:0]         rsp_id;
   logic [31:0]        rsp_w;
   logic [5:0]         rsp_l;
   logic               rsp_ovf;
   logic               busy;
   logic [15:0]        op_count;

   logic [AW-1:0]      op_a [NREQ];
   logic [AW-1:0]      op_b [NREQ];

   int total = 0;
   int bad   = 0;
   int m_ptr;
   int m_cnt;

   always #5 clk = ~clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*AW +: AW] = op_a[i];
         req_b[i*AW +: AW] = op_b[i];
      end
   end

   mulpop_arbiter #(
      .NREQ (NREQ),
      .AW   (AW)
   ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_w     (rsp_w),
      .rsp_l     (rsp_l),
      .rsp_ovf   (rsp_ovf),
      .busy      (busy),
      .op_count  (op_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (ptr + k) % NREQ;
         if (((v >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int g);
      if (g < 0) return '0;
      return NREQ'(1) << g;
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = AW'($urandom);
         op_b[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom);
      end
   endtask

   task automatic do_reset();
      n_reset   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      step();
      step();
      n_reset = 1'b1;
      m_ptr   = NREQ - 1;
      m_cnt   = 0;
   endtask

   // Caller drives req_valid/op_* shortly after a rising edge, then calls this.
   task automatic do_op(input string tag, input int stall, input bit drop);
      int              g;
      int              lat;
      logic [AW-1:0]   ea, eb;
      logic [63:0]     prod;
      logic [31:0]     ew;
      logic [NREQ-1:0] rdy_or;
      logic            hold_ok;
      logic [31:0]     w0;
      logic [5:0]      l0;
      #1;
      g = rr_pick(req_valid, m_ptr);
      chk({tag, "_grant"}, req_ready, oh(g));
      ea   = op_a[g];
      eb   = op_b[g];
      prod = 64'(ea) * 64'(eb);
      ew   = prod[31:0];
      rsp_ready = (stall == 0);
      step();
      m_ptr = g;
      if (drop) req_valid = req_valid & ~oh(g);
      op_a[g] = AW'($urandom);
      op_b[g] = AW'($urandom);
      lat    = 0;
      rdy_or = '0;
      while (!rsp_valid && lat < 200) begin
         rdy_or |= req_ready;
         step();
         lat++;
      end
      chk({tag, "_valid"}, rsp_valid, 1);
`ifdef MULPOP_EARLY_TERM_EN
      if (eb == '0) chk({tag, "_lat"}, lat, 3);
`else
      chk({tag, "_lat"}, lat, AW + 2);
`endif
      chk({tag, "_id"}, rsp_id, g);
      chk({tag, "_w"}, rsp_w, ew);
      chk({tag, "_l"}, rsp_l, $countones(ew));
      chk({tag, "_ovf"}, rsp_ovf, prod[63:32] != 0);
      chk({tag, "_rdy_busy"}, rdy_or, 0);
      if (stall > 0) begin
         hold_ok = 1'b1;
         w0      = rsp_w;
         l0      = rsp_l;
         rdy_or  = '0;
         for (int i = 0; i < stall; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_w !== w0 || rsp_l !== l0 ||
                rsp_id !== 3'(g) || busy !== 1'b1) hold_ok = 1'b0;
            rdy_or |= req_ready;
         end
         chk({tag, "_hold"}, hold_ok, 1);
         chk({tag, "_stall_rdy"}, rdy_or, 0);
      end
      rsp_ready = 1'b1;
      step();
      m_cnt++;
      chk({tag, "_rsp_drop"}, rsp_valid, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_count"}, op_count, m_cnt & 16'hffff);
      chk({tag, "_next_grant"}, req_ready, oh(rr_pick(req_valid, m_ptr)));
   endtask

   initial begin
      logic quiet;
      n_reset   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      m_ptr = NREQ - 1;
      m_cnt = 0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_count", op_count, 0);
      chk("rst_w", rsp_w, 0);
      chk("rst_ready", req_ready, 0);
      step();
      n_reset = 1'b1;
      step();

      // Single small product from requester 0
      op_a[0] = 24'd3;
      op_b[0] = 24'd5;
      req_valid = 2'b01;
      do_op("t1", 0, 1'b1);

      // Both requesters continuously valid: alternating grants from a fresh reset
      do_reset();
      rand_ops();
      req_valid = '1;
      for (int i = 0; i < 6; i++) do_op("t2", 0, 1'b0);
      chk("t2_total", op_count, 6);

      // Largest operands
      req_valid = '0;
      op_a[1] = 24'hFFFFFF;
      op_b[1] = 24'hFFFFFF;
      req_valid = 2'b10;
      do_op("t3", 0, 1'b1);

      // Response backpressure with both requesters waiting
      rand_ops();
      req_valid = '1;
      do_op("t4", 10, 1'b0);
      do_op("t4b", 0, 1'b0);

      // Zero multiplier
      req_valid = '0;
      op_a[0] = 24'h000010;
      op_b[0] = 24'h0;
      req_valid = 2'b01;
      do_op("t6", 0, 1'b1);

      // Randomized requests, stalls and drops
      for (int n = 0; n < 20; n++) begin
         rand_ops();
         req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         do_op("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a multiply
      req_valid = '0;
      op_a[0] = 24'h123456;
      op_b[0] = 24'h654321;
      req_valid = 2'b01;
      #1;
      chk("t5_grant", req_ready, 2'b01);
      step();
      req_valid = '0;
      repeat (10) step();
      chk("t5_busy_pre", busy, 1);
      n_reset = 1'b0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_valid", rsp_valid, 0);
      chk("t5_count", op_count, 0);
      chk("t5_w", rsp_w, 0);
      chk("t5_l", rsp_l, 0);
      chk("t5_ovf", rsp_ovf, 0);
      chk("t5_id", rsp_id, 0);
      chk("t5_ready", req_ready, 0);
      step();
      n_reset = 1'b1;
      m_ptr   = NREQ - 1;
      m_cnt   = 0;
      quiet   = 1'b0;
      repeat (40) begin
         step();
         quiet |= rsp_valid | busy;
      end
      chk("t5_no_rsp", quiet, 0);
      rand_ops();
      req_valid = '1;
      do_op("t5_after", 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
